// File: rtl/uart_echo_responder_if.sv
// Serial lines and status strobes of the UART echo responder.
// slave: responder side; master: initiator/observer side.
interface uart_echo_responder_if #(
  parameter int unsigned FRAME_WD = 8
) ();
  logic                uart_rx;
  logic                cts;
  logic                uart_tx;
  logic [FRAME_WD-1:0] rx_frame;
  logic                rx_done;
  logic                frame_error;
  logic                parity_error;
  logic                overflow;
  logic                tx_done;

  modport master (
    output uart_rx, cts,
    input  uart_tx, rx_frame, rx_done, frame_error, parity_error, overflow, tx_done
  );

  modport slave (
    input  uart_rx, cts,
    output uart_tx, rx_frame, rx_done, frame_error, parity_error, overflow, tx_done
  );
endinterface

// File: rtl/uart_echo_responder.sv
// UART receiver feeding a small FIFO whose frames are echoed back on uart_tx when cts allows.
// Define UART_ECHO_PARITY_EN to add an even parity bit on both lines.
module uart_echo_responder #(
  parameter int unsigned CLK_FREQUENCE = 50_000_000,
  parameter int unsigned BAUD_RATE     = 921600,
  parameter int unsigned FRAME_WD      = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input logic                  clk,
  input logic                  rst,
  uart_echo_responder_if.slave bus
);
  localparam int unsigned BAUD_CNT = CLK_FREQUENCE / BAUD_RATE;
  localparam int unsigned HALF_CNT = BAUD_CNT / 2;
  localparam int unsigned CW       = $clog2(BAUD_CNT + 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned PW       = AW + 1;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA,
`ifdef UART_ECHO_PARITY_EN
    R_PARITY,
`endif
    R_STOP, R_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA,
`ifdef UART_ECHO_PARITY_EN
    T_PARITY,
`endif
    T_STOP
  } tx_state_t;

  logic rx_s1, rx_s2, rx_d;

  rx_state_t           rx_state, rx_state_n;
  logic [CW-1:0]       rx_cnt;
  logic                rx_tick;
  logic [3:0]          rx_bit;
  logic [FRAME_WD-1:0] rx_shift, rx_frame_q;
  logic                rx_done_q, frame_err_q, rx_par_bad;

  tx_state_t           tx_state, tx_state_n;
  logic [CW-1:0]       tx_cnt;
  logic                tx_tick, pop, tx_done_c, tx_line;
  logic [3:0]          tx_bit;
  logic [FRAME_WD-1:0] tx_shift;

  logic [FRAME_WD-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                full, empty;

  always_ff @(posedge clk) begin
    if (rst) {rx_s1, rx_s2, rx_d} <= '1;
    else     {rx_s1, rx_s2, rx_d} <= {bus.uart_rx, rx_s1, rx_s2};
  end

  always_comb begin
    rx_tick    = (rx_state == R_START) ? (rx_cnt == CW'(HALF_CNT - 1))
                                       : (rx_cnt == CW'(BAUD_CNT - 1));
    rx_state_n = rx_state;
    unique case (rx_state)
      R_IDLE:      if (rx_d && !rx_s2) rx_state_n = R_START;
      R_START:     if (rx_tick) rx_state_n = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:      if (rx_tick && rx_bit == 4'(FRAME_WD - 1))
`ifdef UART_ECHO_PARITY_EN
                     rx_state_n = R_PARITY;
      R_PARITY:    if (rx_tick) rx_state_n = R_STOP;
`else
                     rx_state_n = R_STOP;
`endif
      R_STOP:      if (rx_tick) rx_state_n = rx_s2 ? R_IDLE : R_WAIT_HIGH;
      R_WAIT_HIGH: if (rx_s2) rx_state_n = R_IDLE;
      default:     rx_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= R_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_frame_q  <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state    <= rx_state_n;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_cnt      <= (rx_state_n != rx_state || rx_tick) ? '0 : rx_cnt + 1'b1;
      unique case (rx_state)
        R_START: rx_bit <= '0;
        R_DATA: if (rx_tick) begin
          rx_shift <= {rx_s2, rx_shift[FRAME_WD-1:1]};
          rx_bit   <= rx_bit + 1'b1;
        end
        R_STOP: if (rx_tick) begin
          frame_err_q <= !rx_s2;
          if (rx_s2 && !rx_par_bad) begin
            rx_done_q  <= 1'b1;
            rx_frame_q <= rx_shift;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_ECHO_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_par_bad <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      par_err_q <= 1'b0;
      if (rx_state == R_START) rx_par_bad <= 1'b0;
      if (rx_state == R_PARITY && rx_tick) rx_par_bad <= rx_s2 ^ (^rx_shift);
      // A bad parity frame still waits for its stop sample before reporting.
      if (rx_state == R_STOP && rx_tick) par_err_q <= rx_par_bad;
    end
  end
  assign bus.parity_error = par_err_q;
`else
  assign rx_par_bad       = 1'b0;
  assign bus.parity_error = 1'b0;
`endif

  assign full  = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
  assign empty = (wr_ptr == rd_ptr);

  always_ff @(posedge clk) begin
    if (rx_done_q && !full) mem[wr_ptr[AW-1:0]] <= rx_frame_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rx_done_q && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop)                rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef UART_ECHO_PARITY_EN
  logic tx_par;
`endif

  always_comb begin
    tx_tick    = (tx_cnt == CW'(BAUD_CNT - 1));
    tx_state_n = tx_state;
    pop        = 1'b0;
    tx_done_c  = 1'b0;
    tx_line    = 1'b1;
    unique case (tx_state)
      T_IDLE: if (!empty && bus.cts) begin
        pop        = 1'b1;
        tx_state_n = T_START;
      end
      T_START: begin
        tx_line = 1'b0;
        if (tx_tick) tx_state_n = T_DATA;
      end
      T_DATA: begin
        tx_line = tx_shift[0];
        if (tx_tick && tx_bit == 4'(FRAME_WD - 1))
`ifdef UART_ECHO_PARITY_EN
          tx_state_n = T_PARITY;
      end
      T_PARITY: begin
        tx_line = tx_par;
        if (tx_tick) tx_state_n = T_STOP;
`else
          tx_state_n = T_STOP;
`endif
      end
      T_STOP: if (tx_tick) begin
        tx_done_c = 1'b1;
        // Chain straight into the next start bit so queued echoes leave gap-free.
        if (!empty && bus.cts) begin
          pop        = 1'b1;
          tx_state_n = T_START;
        end else begin
          tx_state_n = T_IDLE;
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef UART_ECHO_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= (tx_state == T_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (pop) begin
        tx_shift <= mem[rd_ptr[AW-1:0]];
        tx_bit   <= '0;
`ifdef UART_ECHO_PARITY_EN
        tx_par   <= ^mem[rd_ptr[AW-1:0]];
`endif
      end else if (tx_state == T_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[FRAME_WD-1:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

  assign bus.uart_tx     = tx_line;
  assign bus.rx_frame    = rx_frame_q;
  assign bus.rx_done     = rx_done_q;
  assign bus.frame_error = frame_err_q;
  assign bus.overflow    = rx_done_q & full;
  assign bus.tx_done     = tx_done_c;
endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: line-level sender, wire-level echo decoder and event counters.
module tb_uart_echo_responder;
  localparam int BAUD = 54;
`ifdef UART_ECHO_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_echo_responder_if #(.FRAME_WD(8)) bus ();

  uart_echo_responder #(
    .CLK_FREQUENCE(50_000_000),
    .BAUD_RATE    (921600),
    .FRAME_WD     (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  int n_rxd = 0, n_ferr = 0, n_perr = 0, n_ovf = 0, n_txd = 0, n_fall = 0, n_b2b = 0;
  int last_rxd_cyc = -100, last_fall_cyc = -100, last_txd_cyc = -100, ovf_rxd_idx = -1;
  logic [7:0] rx_seen[$];
  logic [7:0] tx_seen[$];
  bit          dec_busy = 1'b0;
  int          dec_t, dec_k;
  logic [NB-1:0] dec_bits;

  // Observe the pins at mid-cycle; decode uart_tx as a plain UART receiver would.
  always @(negedge clk) begin
    if (rst) begin
      dec_busy = 1'b0;
    end else begin
      if (bus.rx_done) begin
        n_rxd++;
        last_rxd_cyc = cyc;
        rx_seen.push_back(bus.rx_frame);
      end
      if (bus.frame_error)  n_ferr++;
      if (bus.parity_error) n_perr++;
      if (bus.overflow) begin
        n_ovf++;
        ovf_rxd_idx = n_rxd;
      end
      if (bus.tx_done) begin
        n_txd++;
        check("tx_frame_length", cyc - last_fall_cyc, NB * BAUD - 1);
        last_txd_cyc = cyc;
      end
      if (!dec_busy) begin
        if (bus.uart_tx == 1'b0) begin
          dec_busy = 1'b1;
          dec_t    = 0;
          n_fall++;
          if (last_txd_cyc == cyc - 1) n_b2b++;
          last_fall_cyc = cyc;
        end
      end else begin
        dec_t++;
        if (dec_t >= BAUD / 2 && (dec_t - BAUD / 2) % BAUD == 0) begin
          dec_k = (dec_t - BAUD / 2) / BAUD;
          dec_bits[dec_k] = bus.uart_tx;
          if (dec_k == NB - 1) begin
            dec_busy = 1'b0;
            check("tx_start_bit", dec_bits[0], 0);
            check("tx_stop_bit", dec_bits[NB-1], 1);
`ifdef UART_ECHO_PARITY_EN
            check("tx_parity_bit", dec_bits[9], ^dec_bits[8:1]);
`endif
            tx_seen.push_back(dec_bits[8:1]);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: good frame, 1: stop bit low, 2: parity bit inverted (parity builds)
  task automatic send_frame(input logic [7:0] d, input int mode);
    logic [NB-1:0] bits;
    bits        = '1;
    bits[0]     = 1'b0;
    bits[8:1]   = d;
`ifdef UART_ECHO_PARITY_EN
    bits[9]     = (^d) ^ (mode == 2);
`endif
    bits[NB-1]  = (mode != 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) begin
      bus.uart_rx = bits[i];
      idle(BAUD);
    end
    bus.uart_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         mode;
    int         exp_rxd;
    int         exp_err;
    int         exp_echo;
  } vec_t;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    logic [7:0] ovf_data[5];
    logic [7:0] rst_data[2];
    int b_rxd, b_ferr, b_perr, b_ovf, b_txd, b_fall, b_b2b, b_tx;
    int target, waited;

    vecs.push_back(vec_t'{8'hA5, 0, 1, 0, 1});
    vecs.push_back(vec_t'{8'h3C, 1, 0, 1, 0});
    vecs.push_back(vec_t'{8'h00, 0, 1, 0, 1});
    vecs.push_back(vec_t'{8'hFF, 0, 1, 0, 1});
    vecs.push_back(vec_t'{8'h80, 1, 0, 1, 0});
    vecs.push_back(vec_t'{8'h01, 0, 1, 0, 1});
`ifdef UART_ECHO_PARITY_EN
    vecs.push_back(vec_t'{8'h01, 2, 0, 1, 0});
    vecs.push_back(vec_t'{8'h01, 0, 1, 0, 1});
`endif

    bus.uart_rx = 1'b1;
    bus.cts     = 1'b1;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_uart_tx", bus.uart_tx, 1);
    check("reset_rx_frame", bus.rx_frame, 0);
    check("reset_rx_done", bus.rx_done, 0);
    check("reset_tx_done", bus.tx_done, 0);
    check("reset_overflow", bus.overflow, 0);
    check("reset_frame_error", bus.frame_error, 0);
    check("reset_parity_error", bus.parity_error, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20);

    for (int i = 0; i < vecs.size(); i++) begin
      b_rxd = n_rxd; b_ferr = n_ferr; b_perr = n_perr; b_txd = n_txd; b_fall = n_fall;
      b_tx  = tx_seen.size();
      send_frame(vecs[i].data, vecs[i].mode);
      idle(NB * BAUD + 150);
      check($sformatf("vec%0d_rx_done", i), n_rxd - b_rxd, vecs[i].exp_rxd);
      if (vecs[i].mode == 2) begin
        check($sformatf("vec%0d_parity_error", i), n_perr - b_perr, vecs[i].exp_err);
        check($sformatf("vec%0d_frame_error", i), n_ferr - b_ferr, 0);
      end else begin
        check($sformatf("vec%0d_frame_error", i), n_ferr - b_ferr, vecs[i].exp_err);
        check($sformatf("vec%0d_parity_error", i), n_perr - b_perr, 0);
      end
      check($sformatf("vec%0d_tx_falls", i), n_fall - b_fall, vecs[i].exp_echo);
      check($sformatf("vec%0d_tx_done", i), n_txd - b_txd, vecs[i].exp_echo);
      check($sformatf("vec%0d_echo_count", i), tx_seen.size() - b_tx, vecs[i].exp_echo);
      if (vecs[i].exp_echo != 0 && tx_seen.size() > b_tx) begin
        check($sformatf("vec%0d_echo_data", i), tx_seen[$], vecs[i].data);
        check($sformatf("vec%0d_rx_frame", i), bus.rx_frame, vecs[i].data);
        check($sformatf("vec%0d_latency", i), last_fall_cyc - last_rxd_cyc, 2);
      end
    end

    // Short low glitch must be ignored, then a normal frame still gets through.
    b_rxd = n_rxd; b_ferr = n_ferr; b_fall = n_fall;
    @(posedge clk);
    #1 bus.uart_rx = 1'b0;
    idle(10);
    bus.uart_rx = 1'b1;
    idle(200);
    check("glitch_rx_done", n_rxd - b_rxd, 0);
    check("glitch_frame_error", n_ferr - b_ferr, 0);
    check("glitch_tx_falls", n_fall - b_fall, 0);
    send_frame(8'h5A, 0);
    idle(NB * BAUD + 150);
    check("post_glitch_rx_frame", bus.rx_frame, 8'h5A);
    check("post_glitch_echo", tx_seen[$], 8'h5A);

    // Fill the FIFO with cts low; fifth frame overflows.
    ovf_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus.cts = 1'b0;
    b_rxd = n_rxd; b_ovf = n_ovf; b_txd = n_txd; b_fall = n_fall; b_b2b = n_b2b;
    b_tx  = tx_seen.size();
    for (int i = 0; i < 5; i++) send_frame(ovf_data[i], 0);
    idle(100);
    check("ovf_rx_done", n_rxd - b_rxd, 5);
    check("ovf_pulses", n_ovf - b_ovf, 1);
    check("ovf_on_fifth", ovf_rxd_idx - b_rxd, 5);
    check("ovf_cts_holds_tx", n_fall - b_fall, 0);
    bus.cts = 1'b1;
    idle(4 * NB * BAUD + 200);
    check("ovf_echo_count", tx_seen.size() - b_tx, 4);
    check("ovf_tx_done", n_txd - b_txd, 4);
    check("ovf_no_gaps", n_b2b - b_b2b, 3);
    for (int i = 0; i < 4; i++)
      if (b_tx + i < tx_seen.size())
        check($sformatf("ovf_echo%0d", i), tx_seen[b_tx + i], ovf_data[i]);

    // cts dropping mid-echo must not cut the frame short.
    b_txd = n_txd; b_tx = tx_seen.size(); b_fall = n_fall;
    send_frame(8'h96, 0);
    waited = 0;
    while (n_fall == b_fall && waited < 300) begin
      idle(1);
      waited++;
    end
    check("cts_mid_fall_seen", n_fall - b_fall, 1);
    bus.cts = 1'b0;
    idle(NB * BAUD + 50);
    check("cts_mid_tx_done", n_txd - b_txd, 1);
    if (tx_seen.size() > b_tx) check("cts_mid_echo", tx_seen[$], 8'h96);
    bus.cts = 1'b1;
    idle(50);

    // Reset 200 cycles into an echo aborts it and empties everything.
    rst_data = '{8'hFF, 8'h00};
    for (int r = 0; r < 2; r++) begin
      b_fall = n_fall;
      send_frame(rst_data[r], 0);
      waited = 0;
      while (n_fall == b_fall && waited < 300) begin
        idle(1);
        waited++;
      end
      check($sformatf("rst%0d_echo_started", r), n_fall - b_fall, 1);
      target = last_fall_cyc + 200;
      while (cyc < target) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst%0d_uart_tx_high", r), bus.uart_tx, 1);
      check($sformatf("rst%0d_rx_frame_clear", r), bus.rx_frame, 0);
      idle(2);
      rst = 1'b0;
      b_txd = n_txd; b_fall = n_fall;
      idle(NB * BAUD + 300);
      check($sformatf("rst%0d_no_tx_done", r), n_txd - b_txd, 0);
      check($sformatf("rst%0d_fifo_empty", r), n_fall - b_fall, 0);
    end

    // Random traffic against a plain in-order echo model.
    b_tx = tx_seen.size();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 0);
    end
    idle(NB * BAUD + 300);
    check("rand_echo_count", tx_seen.size() - b_tx, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (b_tx + i < tx_seen.size())
        check($sformatf("rand_echo%0d", i), tx_seen[b_tx + i], exp_q[i]);
    check("rand_rx_frame", bus.rx_frame, exp_q[$]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_echo_responder.md
UART_ECHO_RESPONDER -- requirements
Module: uart_echo_responder

Interface
REQ-001 SHALL have parameter CLK_FREQUENCE, default 50_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 921600, line bit rate; BAUD_CNT = CLK_FREQUENCE/BAUD_RATE (floor), clock cycles per bit.
REQ-003 SHALL have parameter FRAME_WD, default 8, data bits per frame, legal 5..9.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, echo buffer depth, power of two, 2..16.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port uart_rx  input  1  asynchronous serial line from the initiator.
REQ-008 SHALL have port cts  input  1  transmit permission; a new echo frame starts only while 1.
REQ-009 SHALL have port uart_tx  output  1  serial echo line, idle high.
REQ-010 SHALL have port rx_frame  output  FRAME_WD  last good received data.
REQ-011 SHALL have port rx_done  output  1  one-cycle pulse, rx_frame valid.
REQ-012 SHALL have port frame_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-013 SHALL have port parity_error  output  1  one-cycle pulse, parity mismatch.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse, good frame dropped because FIFO full.
REQ-015 SHALL have port tx_done  output  1  one-cycle pulse, echo stop bit completed.

Function
REQ-016 uart_rx SHALL pass through a 2-flop synchronizer; all receive decisions use the synchronized value.
REQ-017 Receiver FSM SHALL use states R_IDLE, R_START, R_DATA, R_PARITY (macro builds only), R_STOP, R_WAIT_HIGH.
REQ-018 R_IDLE -> R_START on synchronized high-to-low edge; R_START samples at BAUD_CNT/2 cycles, returns to R_IDLE if high (glitch), else -> R_DATA.
REQ-019 Data bits SHALL be sampled every BAUD_CNT cycles thereafter, LSB first, FRAME_WD bits.
REQ-020 Stop sample high: rx_done pulses the following cycle, rx_frame updates the same cycle, FSM -> R_IDLE.
REQ-021 Stop sample low: frame_error pulses, no rx_done, frame discarded, FSM -> R_WAIT_HIGH until line high, then R_IDLE.
REQ-022 Each rx_done SHALL write rx_frame into the FIFO on the same edge unless FIFO full at that edge (pop in the same cycle not counted); if full, frame dropped and overflow pulses with rx_done.
REQ-023 Transmitter FSM SHALL use states T_IDLE, T_START, T_DATA, T_PARITY (macro builds only), T_STOP; each bit held exactly BAUD_CNT cycles.
REQ-024 In T_IDLE with FIFO non-empty and cts=1, FIFO SHALL pop that cycle and uart_tx go low the next cycle (T_START).
REQ-025 Latency: with FIFO empty, tx idle, cts=1, rx_done at cycle N gives pop at N+1, uart_tx low at N+2.
REQ-026 Data bits SHALL transmit LSB first; tx_done pulses on the last cycle of the stop bit, FSM -> T_IDLE; back-to-back frames have no idle gap.
REQ-027 cts deasserted mid-frame SHALL NOT abort the frame in progress.
REQ-028 FIFO order SHALL be first-in first-out; pointer wrap at FIFO_DEPTH is seamless.

Reset
REQ-029 While rst=1 at a clock edge: uart_tx=1, rx_frame=0, all pulse outputs 0, both FSMs idle, FIFO empty, counters 0, synchronizer loaded with 1.
REQ-030 Reset mid-transmit SHALL abort the frame; uart_tx high the cycle after the reset edge; no tx_done for the aborted frame.

Configuration
REQ-031 Macro UART_ECHO_PARITY_EN defined: even parity bit follows data on both rx and tx; rx mismatch pulses parity_error in place of rx_done, frame not written, FSM still checks stop bit.
REQ-032 Macro UART_ECHO_PARITY_EN undefined: no parity bit on either line, R_PARITY/T_PARITY absent, parity_error tied 0.

Verification (CLK_FREQUENCE 50_000_000, BAUD_RATE 921600, BAUD_CNT 54, FRAME_WD 8, FIFO_DEPTH 4)
REQ-033 Drive 0xA5 on uart_rx, cts=1 -> one rx_done, rx_frame=0xA5, uart_tx low 2 cycles later, echoes 0xA5 at 54 cycles/bit, one tx_done.
REQ-034 Drive 0x3C with stop bit low -> frame_error pulse, no rx_done, uart_tx stays high.
REQ-035 cts=0, send 0x11,0x22,0x33,0x44,0x55 -> overflow pulse with 5th rx_done only; cts=1 -> echoes 0x11,0x22,0x33,0x44 in order, no gaps.
REQ-036 uart_rx low for 10 cycles then high -> no rx_done, no frame_error, next valid frame 0x5A received correctly.
REQ-037 Assert rst 200 cycles into an echo of 0xFF -> uart_tx high next cycle, no tx_done, FIFO empty afterward.
REQ-038 With UART_ECHO_PARITY_EN, send 0x01 with parity bit 0 -> parity_error pulse, no rx_done, no echo; parity bit 1 -> echo 0x01 with parity 1.
